frame_read_arbiter: RTL and testbench

Sequences and shares the read side of the ping-pong frame buffer between two downstream consumers. Each completed frame is granted whole to one consumer, chosen round-robin among those requesting. A frame nobody requests is drained and counted as dropped. The block sits between the buffer's read stream (data/valid/ready plus frame-ready and overflow pulses) and the two consumer streams, and reports frame, drop and overflow statistics.

---
 rtl/frame_read_arbiter.sv | 90 +++++++++
 tb/tb_frame_read_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_read_arbiter.sv
// frame_read_arbiter: hands whole frames from the read bank to one of two consumers round-robin, drops unclaimed frames
module frame_read_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] buf_data_i,
    input  logic             buf_valid_i,
    output logic             buf_ready_o,
    input  logic             buf_frame_ready_i,
    input  logic             buf_overflow_i,
    input  logic             c0_req_i,
    output logic [WIDTH-1:0] c0_data_o,
    output logic             c0_valid_o,
    input  logic             c0_ready_i,
    output logic             c0_last_o,
    input  logic             c1_req_i,
    output logic [WIDTH-1:0] c1_data_o,
    output logic             c1_valid_o,
    input  logic             c1_ready_i,
    output logic             c1_last_o,
    output logic             abort_o,
    output logic             busy_o,
    output logic [1:0]       grant_o,
    output logic [CNT_W-1:0] frame_count_o,
    output logic [CNT_W-1:0] drop_count_o,
    output logic [CNT_W-1:0] overflow_count_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    typedef enum logic [1:0] {IDLE, ARB, XFER, DROP} state_t;
    state_t state, state_n;
    logic [1:0] gsel;
    logic last_grant, xfer, active, acc, at_last, done, abort, sel0, sel1;
    logic [CW-1:0] word_cnt;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + CNT_W'(1);
    endfunction
    always_comb begin
        gsel = (c0_req_i && c1_req_i) ? (last_grant ? 2'b01 : 2'b10) : {c1_req_i, c0_req_i};
        xfer = state == XFER;
        active = xfer || state == DROP;
        sel0 = xfer && grant_o[0];
        sel1 = xfer && grant_o[1];
        buf_ready_o = (state == DROP) || (sel0 && c0_ready_i) || (sel1 && c1_ready_i);
        acc = buf_valid_i && buf_ready_o;
        at_last = word_cnt == CW'(DEPTH - 1);
        done = active && acc && at_last;
        abort = active && buf_frame_ready_i && !done;
        state_n = state;
        case (state)
            IDLE:    state_n = buf_frame_ready_i ? ARB : IDLE;
            ARB:     state_n = |gsel ? XFER : DROP;
            default: state_n = buf_frame_ready_i ? ARB : done ? IDLE : state;
        endcase
        c0_valid_o = sel0 && buf_valid_i;
        c1_valid_o = sel1 && buf_valid_i;
        c0_data_o = sel0 ? buf_data_i : '0;
        c1_data_o = sel1 ? buf_data_i : '0;
        // an aborting cycle never flags last, even if the counter sits at DEPTH-1
        c0_last_o = sel0 && buf_valid_i && at_last && !abort;
        c1_last_o = sel1 && buf_valid_i && at_last && !abort;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            grant_o <= '0;
            busy_o <= 1'b0;
            abort_o <= 1'b0;
            word_cnt <= '0;
            last_grant <= 1'b1;
            frame_count_o <= '0;
            drop_count_o <= '0;
            overflow_count_o <= '0;
        end else begin
            state <= state_n;
            grant_o <= (state == ARB) ? gsel : (state_n == XFER ? grant_o : 2'b00);
            busy_o <= state_n != IDLE;
            abort_o <= abort;
            word_cnt <= (active && !done && !buf_frame_ready_i) ? word_cnt + CW'(acc) : '0;
            if (xfer && done) begin
                last_grant <= grant_o[1];
                frame_count_o <= sat_inc(frame_count_o);
            end
            if ((state == DROP && done) || abort) drop_count_o <= sat_inc(drop_count_o);
            if (buf_overflow_i) overflow_count_o <= sat_inc(overflow_count_o);
        end
    end
endmodule

// File: tb/tb_frame_read_arbiter.sv
// tb_frame_read_arbiter: directed scenario tests for frame_read_arbiter with a 2-bit statistics width
module tb_frame_read_arbiter;
    localparam int W = 32;
    localparam int D = 16;
    localparam int CW = 2;
    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic [W-1:0] buf_data_i = '0;
    logic buf_valid_i = 0, buf_frame_ready_i = 0, buf_overflow_i = 0;
    logic c0_req_i = 0, c0_ready_i = 0, c1_req_i = 0, c1_ready_i = 0;
    logic buf_ready_o, c0_valid_o, c0_last_o, c1_valid_o, c1_last_o, abort_o, busy_o;
    logic [W-1:0] c0_data_o, c1_data_o;
    logic [1:0] grant_o;
    logic [CW-1:0] frame_count_o, drop_count_o, overflow_count_o;
    int checks = 0, errors = 0;

    frame_read_arbiter #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .buf_data_i(buf_data_i), .buf_valid_i(buf_valid_i), .buf_ready_o(buf_ready_o),
        .buf_frame_ready_i(buf_frame_ready_i), .buf_overflow_i(buf_overflow_i),
        .c0_req_i(c0_req_i), .c0_data_o(c0_data_o), .c0_valid_o(c0_valid_o),
        .c0_ready_i(c0_ready_i), .c0_last_o(c0_last_o),
        .c1_req_i(c1_req_i), .c1_data_o(c1_data_o), .c1_valid_o(c1_valid_o),
        .c1_ready_i(c1_ready_i), .c1_last_o(c1_last_o),
        .abort_o(abort_o), .busy_o(busy_o), .grant_o(grant_o),
        .frame_count_o(frame_count_o), .drop_count_o(drop_count_o),
        .overflow_count_o(overflow_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic do_reset();
        rst_ni = 0;
        {buf_valid_i, buf_frame_ready_i, buf_overflow_i} = '0;
        {c0_req_i, c0_ready_i, c1_req_i, c1_ready_i} = '0;
        buf_data_i = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
    endtask

    task automatic pulse_frame();
        buf_frame_ready_i = 1;
        @(negedge clk_i);
        buf_frame_ready_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({buf_ready_o, c0_valid_o, c1_valid_o, c0_last_o, c1_last_o, abort_o, busy_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000", {buf_ready_o, c0_valid_o, c1_valid_o, c0_last_o, c1_last_o, abort_o, busy_o});
        end
        checks++;
        if ({grant_o, frame_count_o, drop_count_o, overflow_count_o} !== 8'b0) begin
            errors++;
            $display("FAIL reset_stats: got %b want 0", {grant_o, frame_count_o, drop_count_o, overflow_count_o});
        end
    endtask

    task automatic test_single_c0();
        do_reset();
        c0_req_i = 1;
        c0_ready_i = 1;
        pulse_frame();
        checks++;
        if ({busy_o, grant_o, buf_ready_o} !== 4'b1000) begin
            errors++;
            $display("FAIL single_arb: busy,grant,ready got %b want 1000", {busy_o, grant_o, buf_ready_o});
        end
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: got %b want 01", grant_o);
        end
        for (int i = 0; i < D; i++) begin
            buf_data_i = W'(i);
            buf_valid_i = 1;
            #1;
            checks++;
            if (c0_valid_o !== 1 || c0_data_o !== W'(i) || c0_last_o !== (i == D - 1) || c1_valid_o !== 0 || buf_ready_o !== 1) begin
                errors++;
                $display("FAIL single_word%0d: v=%b d=%0d last=%b c1v=%b rdy=%b want v=1 d=%0d last=%b c1v=0 rdy=1",
                         i, c0_valid_o, c0_data_o, c0_last_o, c1_valid_o, buf_ready_o, i, i == D - 1);
            end
            @(negedge clk_i);
        end
        buf_valid_i = 0;
        checks++;
        if ({busy_o, grant_o} !== 3'b000 || frame_count_o !== 2'd1) begin
            errors++;
            $display("FAIL single_done: busy=%b grant=%b frames=%0d want busy=0 grant=00 frames=1", busy_o, grant_o, frame_count_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        {c0_req_i, c1_req_i, c0_ready_i, c1_ready_i} = 4'b1111;
        for (int f = 0; f < 3; f++) begin
            logic [1:0] exp_g;
            exp_g = (f % 2 == 0) ? 2'b01 : 2'b10;
            pulse_frame();
            @(negedge clk_i);
            checks++;
            if (grant_o !== exp_g) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b want %b", f, grant_o, exp_g);
            end
            for (int i = 0; i < D; i++) begin
                buf_data_i = W'(f * 100 + i);
                buf_valid_i = 1;
                #1;
                checks++;
                if ({c1_valid_o, c0_valid_o} !== exp_g) begin
                    errors++;
                    $display("FAIL rr_valid%0d_%0d: got %b want %b", f, i, {c1_valid_o, c0_valid_o}, exp_g);
                end
                @(negedge clk_i);
            end
            buf_valid_i = 0;
            checks++;
            if (frame_count_o !== CW'(f + 1)) begin
                errors++;
                $display("FAIL rr_frames%0d: got %0d want %0d", f, frame_count_o, f + 1);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        pulse_frame();
        @(negedge clk_i);
        for (int i = 0; i < D; i++) begin
            buf_valid_i = 1;
            buf_data_i = W'(i);
            #1;
            checks++;
            if (buf_ready_o !== 1 || c0_valid_o !== 0 || c1_valid_o !== 0 || grant_o !== 2'b00 || busy_o !== 1) begin
                errors++;
                $display("FAIL drop_word%0d: rdy=%b c0v=%b c1v=%b grant=%b busy=%b want 1 0 0 00 1",
                         i, buf_ready_o, c0_valid_o, c1_valid_o, grant_o, busy_o);
            end
            @(negedge clk_i);
        end
        buf_valid_i = 0;
        checks++;
        if (drop_count_o !== 2'd1 || busy_o !== 0 || frame_count_o !== 2'd0) begin
            errors++;
            $display("FAIL drop_done: drops=%0d busy=%b frames=%0d want 1 0 0", drop_count_o, busy_o, frame_count_o);
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        do_reset();
        c0_req_i = 1;
        pulse_frame();
        @(negedge clk_i);
        for (int t = 0; t < 40 && k < D; t++) begin
            c0_ready_i = (t % 2 == 0);
            buf_valid_i = 1;
            buf_data_i = W'(200 + k);
            #1;
            checks++;
            if (buf_ready_o !== c0_ready_i || (c0_ready_i && (c0_data_o !== W'(200 + k) || c0_last_o !== (k == D - 1)))) begin
                errors++;
                $display("FAIL bp_cycle%0d: rdy=%b d=%0d last=%b want rdy=%b d=%0d last=%b",
                         t, buf_ready_o, c0_data_o, c0_last_o, c0_ready_i, 200 + k, k == D - 1);
            end
            if (c0_ready_i) k++;
            @(negedge clk_i);
        end
        buf_valid_i = 0;
        c0_ready_i = 0;
        checks++;
        if (k != D || frame_count_o !== 2'd1 || busy_o !== 0) begin
            errors++;
            $display("FAIL bp_done: words=%0d frames=%0d busy=%b want %0d 1 0", k, frame_count_o, busy_o, D);
        end
    endtask

    task automatic test_abort();
        do_reset();
        {c0_req_i, c1_req_i, c0_ready_i, c1_ready_i} = 4'b1111;
        pulse_frame();
        @(negedge clk_i);
        for (int i = 0; i < 7; i++) begin
            buf_valid_i = 1;
            buf_data_i = W'(i);
            @(negedge clk_i);
        end
        buf_valid_i = 0;
        checks++;
        if (abort_o !== 0) begin
            errors++;
            $display("FAIL abort_early: got %b want 0", abort_o);
        end
        pulse_frame();
        checks++;
        if (abort_o !== 1 || drop_count_o !== 2'd1 || grant_o !== 2'b00 || busy_o !== 1) begin
            errors++;
            $display("FAIL abort_pulse: abort=%b drops=%0d grant=%b busy=%b want 1 1 00 1", abort_o, drop_count_o, grant_o, busy_o);
        end
        @(negedge clk_i);
        checks++;
        if (abort_o !== 0 || grant_o !== 2'b01) begin
            errors++;
            $display("FAIL abort_regrant: abort=%b grant=%b want 0 01", abort_o, grant_o);
        end
        for (int i = 0; i < D; i++) begin
            buf_valid_i = 1;
            buf_data_i = W'(50 + i);
            #1;
            checks++;
            if (c0_valid_o !== 1 || c0_last_o !== (i == D - 1) || c1_valid_o !== 0) begin
                errors++;
                $display("FAIL abort_refill%0d: v=%b last=%b c1v=%b want 1 %b 0", i, c0_valid_o, c0_last_o, c1_valid_o, i == D - 1);
            end
            @(negedge clk_i);
        end
        buf_valid_i = 0;
        checks++;
        if (frame_count_o !== 2'd1 || drop_count_o !== 2'd1 || busy_o !== 0) begin
            errors++;
            $display("FAIL abort_done: frames=%0d drops=%0d busy=%b want 1 1 0", frame_count_o, drop_count_o, busy_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int p = 1; p <= 5; p++) begin
            buf_overflow_i = 1;
            @(negedge clk_i);
            buf_overflow_i = 0;
            @(negedge clk_i);
            checks++;
            if (overflow_count_o !== CW'(p > 3 ? 3 : p)) begin
                errors++;
                $display("FAIL overflow%0d: got %0d want %0d", p, overflow_count_o, p > 3 ? 3 : p);
            end
        end
    endtask

    task automatic test_async_reset();
        c0_req_i = 1;
        c0_ready_i = 1;
        pulse_frame();
        @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            buf_valid_i = 1;
            buf_data_i = W'(i);
            @(negedge clk_i);
        end
        buf_data_i = 32'h1234;
        #1;
        checks++;
        if (c0_valid_o !== 1 || busy_o !== 1) begin
            errors++;
            $display("FAIL areset_pre: c0v=%b busy=%b want 1 1", c0_valid_o, busy_o);
        end
        #1 rst_ni = 0;
        #1;
        checks++;
        if ({buf_ready_o, c0_valid_o, c0_last_o, abort_o, busy_o, grant_o} !== 7'b0 || c0_data_o !== '0) begin
            errors++;
            $display("FAIL areset_ctrl: got %b data=%0h want 0", {buf_ready_o, c0_valid_o, c0_last_o, abort_o, busy_o, grant_o}, c0_data_o);
        end
        checks++;
        if ({frame_count_o, drop_count_o, overflow_count_o} !== 6'b0) begin
            errors++;
            $display("FAIL areset_stats: got %b want 000000", {frame_count_o, drop_count_o, overflow_count_o});
        end
        @(negedge clk_i);
        buf_valid_i = 0;
        rst_ni = 1;
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_single_c0();
        test_round_robin();
        test_drop();
        test_backpressure();
        test_abort();
        test_overflow();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
